roll_tick_scheduler: RTL and testbench
======================================

Name: roll_tick_scheduler

Overview:
- Sequences the slow-rate timing used by the lab's rolling-number display.
- Replaces a free-running toggled divider clock with single-cycle enable pulses (o_tick) in the i_clk domain.
- Tick interval starts at BASE_PERIOD and doubles after every TICKS_PER_PHASE ticks, giving a decelerating "roll" that ends with o_done.
- Sits between the key/debounce logic (start/abort) and the random-number/seven-segment datapath, which advances one step per o_tick.

Parameters:
- BASE_PERIOD, 2000000, i_clk cycles between ticks in phase 0 (25 Hz at 50 MHz).
- TICKS_PER_PHASE, 8, ticks emitted per phase before the interval doubles.
- NUM_PHASES, 4, number of phases; total ticks = TICKS_PER_PHASE*NUM_PHASES.
- CNT_W, 26, period/counter width; must satisfy BASE_PERIOD<<(NUM_PHASES-1) <= 2^CNT_W.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  level sampled each cycle; high starts or restarts a roll.
- i_abort  in  1  high ends the roll without o_done.
- o_tick  out  1  one-cycle enable pulse; datapath advances on it.
- o_done  out  1  one-cycle pulse coincident with the final o_tick.
- o_busy  out  1  high while in RUN.
- o_phase  out  $clog2(NUM_PHASES) (min 1)  current phase index.

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is asynchronous, active-low on i_rst_n; all state is cleared immediately.
- Reset values: state IDLE; counter 0; tick index 0; phase 0; o_tick=0, o_done=0, o_busy=0, o_phase=0.
- States: IDLE, RUN.
- IDLE: i_start high in cycle c -> RUN in cycle c+1 with counter=0, tick index=0, phase=0. i_abort is ignored.
- RUN:
  - Counter increments every cycle.
  - period = BASE_PERIOD << phase, computed at CNT_W bits.
  - When counter == period-1: counter returns to 0 and the tick index increments.
  - When the tick index wraps at TICKS_PER_PHASE: tick index returns to 0 and phase increments.
- o_tick: decoded only from registered state, as (RUN && counter == period-1). There is no combinational input-to-output path, except the pause gating under the Optional Feature.
- Latency: i_start in cycle 0 -> first o_tick in cycle BASE_PERIOD. Thereafter ticks occur every period cycles.
- o_done: asserted with o_tick when phase == NUM_PHASES-1 and tick index == TICKS_PER_PHASE-1. The next cycle is IDLE with o_busy=0.
- o_busy: equals (state == RUN).
- o_phase: the registered phase; returns to 0 in IDLE.
- i_start during RUN: restart. The next cycle has counter, tick index and phase at 0. A tick or done decoded in the same cycle is still emitted.
- i_abort in RUN without i_start: IDLE next cycle, no o_done. A tick decoded in that cycle is still emitted.
- i_start and i_abort together: i_start wins (restart).
- i_start held high continuously: restarts every cycle, so no tick is ever emitted.
- Counter never exceeds period-1, so there is no wrap-around. The final phase period must fit CNT_W; violating this is a parameter error caught by an elaboration check.

Optional Feature:
- Macro: ROLL_TICK_PAUSE_EN.
- Defined:
  - Adds input i_pause (1 bit).
  - In RUN with i_pause high, counter, tick index and phase hold, and o_tick/o_done are forced 0.
  - Timing resumes exactly where it stopped, so every later tick is delayed by the number of paused cycles.
  - i_start and i_abort keep priority over pause.
- Not defined: the port is absent and behaviour is identical to i_pause tied 0.

Test Plan:
Use BASE_PERIOD=4, TICKS_PER_PHASE=2, NUM_PHASES=3, CNT_W=8; i_start pulsed in cycle 0 for scenarios 1-5.
1. Full roll -> o_busy high in cycles 1..56; o_tick in cycles 4, 8, 16, 24, 40, 56 only; o_phase=1 from cycle 9 and 2 from cycle 25; o_done in cycle 56 only; o_busy=0 in cycle 57.
2. i_abort in cycle 10 -> no further ticks after cycle 8; o_busy=0 from cycle 11; o_done never asserted.
3. i_start again in cycle 16 (same cycle as the third tick) -> tick at 16 still emitted; subsequent ticks at 20, 24, 32, 40, 56, 72; o_done at 72.
4. Reset asserted asynchronously in cycle 30 -> all outputs 0 immediately; no ticks until a new i_start.
5. i_start and i_abort together in cycle 6 -> restart; ticks at 10, 14, 22, 30, 46, 62.
6. (ROLL_TICK_PAUSE_EN) i_pause high in cycles 5-9 -> ticks at 4, 13, 21, 29, 45, 61; no tick during the pause; o_done at 61.

Source files
------------

// File: rtl/roll_tick_scheduler.sv
// roll_tick_scheduler: decelerating tick sequencer for the rolling-number display.
// Emits single-cycle o_tick enables in the i_clk domain. The tick interval starts at
// BASE_PERIOD and doubles after every TICKS_PER_PHASE ticks. o_done marks the final tick.
// Optional feature macro: ROLL_TICK_PAUSE_EN (adds i_pause, which freezes timing while in RUN).
module roll_tick_scheduler #(
    parameter int BASE_PERIOD     = 2000000,
    parameter int TICKS_PER_PHASE = 8,
    parameter int NUM_PHASES      = 4,
    parameter int CNT_W           = 26,
    localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_abort,
`ifdef ROLL_TICK_PAUSE_EN
    input  logic            i_pause,
`endif
    output logic            o_tick,
    output logic            o_done,
    output logic            o_busy,
    output logic [PH_W-1:0] o_phase
);

    localparam int TI_W = (TICKS_PER_PHASE > 1) ? $clog2(TICKS_PER_PHASE) : 1;
    localparam longint unsigned LAST_PERIOD =
        longint'(BASE_PERIOD) << (NUM_PHASES - 1);

    // The slowest period must fit the counter, and every count must be at least 1.
    if (BASE_PERIOD < 1 || TICKS_PER_PHASE < 1 || NUM_PHASES < 1) begin : g_bad_count
        $error("roll_tick_scheduler: BASE_PERIOD, TICKS_PER_PHASE and NUM_PHASES must be >= 1");
    end
    if (LAST_PERIOD > (64'd1 << CNT_W)) begin : g_bad_width
        $error("roll_tick_scheduler: final phase period does not fit CNT_W");
    end

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [TI_W-1:0]   r_tick_idx;
    logic [PH_W-1:0]   r_phase;

    logic              w_pause;
    logic [CNT_W-1:0]  w_period_m1;
    logic              w_at_end;
    logic              w_last_tick;
    logic              w_last_phase;
    logic              w_clear;

`ifdef ROLL_TICK_PAUSE_EN
    assign w_pause = i_pause;
`else
    assign w_pause = 1'b0;
`endif

    // At CNT_W bits a period of exactly 2^CNT_W wraps to 0, so 0-1 still gives the right terminal count.
    assign w_period_m1  = (CNT_W'(BASE_PERIOD) << r_phase) - CNT_W'(1);
    assign w_at_end     = (r_cnt == w_period_m1);
    assign w_last_tick  = (r_tick_idx == TI_W'(TICKS_PER_PHASE - 1));
    assign w_last_phase = (r_phase == PH_W'(NUM_PHASES - 1));

    // Outputs decode registered state only; pause is the single input allowed to gate them.
    assign o_tick  = (r_state == S_RUN) && w_at_end && !w_pause;
    assign o_done  = o_tick && w_last_tick && w_last_phase;
    assign o_busy  = (r_state == S_RUN);
    assign o_phase = r_phase;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: start beats abort, and abort beats the natural end of the roll.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_RUN;
            S_RUN: begin
                if (i_start)      w_next = S_RUN;
                else if (i_abort) w_next = S_IDLE;
                else if (o_done)  w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Timing is held at zero outside RUN and whenever a roll starts, restarts or ends.
    assign w_clear = (r_state != S_RUN) || i_start || i_abort || o_done;

    // Period counter, tick index and phase. All three freeze while paused.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_tick_idx <= '0;
            r_phase    <= '0;
        end else if (w_clear) begin
            r_cnt      <= '0;
            r_tick_idx <= '0;
            r_phase    <= '0;
        end else if (!w_pause) begin
            if (w_at_end) begin
                r_cnt <= '0;
                if (w_last_tick) begin
                    r_tick_idx <= '0;
                    r_phase    <= r_phase + PH_W'(1);
                end else begin
                    r_tick_idx <= r_tick_idx + TI_W'(1);
                end
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_roll_tick_scheduler.sv
// Bench for roll_tick_scheduler. It uses small parameters (BASE_PERIOD=4, TICKS_PER_PHASE=2, NUM_PHASES=3).
// The model derives tick times from cumulative period sums. It is checked every cycle,
// and directed scenarios compare logged tick and done cycles against hand-computed lists.
module tb_roll_tick_scheduler;
    localparam int BP = 4, TPP = 2, NP = 3, CW = 8, TOTAL = TPP * NP, PW = 2, LOGN = 4096;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, pause = 1'b0;
    logic tick, done, busy;
    logic [PW-1:0] phase;

    int errors = 0, checks = 0;
    int cyc = 0, t0 = 0;
    int E[TOTAL];                 // cumulative un-paused RUN cycles at which each tick fires
    bit m_run = 1'b0;
    int m_adv = 0;                // un-paused RUN cycles completed before the current cycle
    int tick_q[$], done_q[$];     // absolute cycles of observed ticks / dones
    int busy_log[LOGN], phase_log[LOGN];

    roll_tick_scheduler #(.BASE_PERIOD(BP), .TICKS_PER_PHASE(TPP), .NUM_PHASES(NP), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
`ifdef ROLL_TICK_PAUSE_EN
        .i_pause(pause),
`endif
        .o_tick(tick), .o_done(done), .o_busy(busy), .o_phase(phase)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - t0);
        end
    endtask

    task automatic chk_list(string name, int q[$], int lo, int hi, int exp[$]);
        int got[$];
        string s;
        bit ok;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) got.push_back(q[i] - lo);
        ok = (got.size() == exp.size());
        if (ok) foreach (got[i]) if (got[i] != exp[i]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            s = "";
            foreach (got[i]) s = {s, $sformatf(" %0d", got[i])};
            s = {s, " | expected"};
            foreach (exp[i]) s = {s, $sformatf(" %0d", exp[i])};
            $display("FAIL %s: got%s", name, s);
        end
    endtask

    function automatic int tick_at(int adv);
        for (int j = 0; j < TOTAL; j++) if (E[j] == adv + 1) return j;
        return -1;
    endfunction

    function automatic int ticks_before(int adv);
        int n = 0;
        for (int j = 0; j < TOTAL; j++) if (E[j] <= adv) n++;
        return n;
    endfunction

    // Per-cycle compare against the model, followed by the model's end-of-cycle update.
    always @(negedge clk) begin : mdl
        int j, e_tick, e_done, e_phase;
        if (!rst_n) begin
            m_run = 1'b0;
            m_adv = 0;
        end
        j       = m_run ? tick_at(m_adv) : -1;
        e_tick  = (j >= 0 && !pause) ? 1 : 0;
        e_done  = (e_tick == 1 && j == TOTAL - 1) ? 1 : 0;
        e_phase = m_run ? ticks_before(m_adv) / TPP : 0;
        chk("tick", int'(tick), e_tick);
        chk("done", int'(done), e_done);
        chk("busy", int'(busy), int'(m_run));
        chk("phase", int'(phase), e_phase);
        if (tick) tick_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (cyc < LOGN) begin
            busy_log[cyc]  = int'(busy);
            phase_log[cyc] = int'(phase);
        end
        if (rst_n) begin
            if (!m_run) begin
                if (start) begin m_run = 1'b1; m_adv = 0; end
            end else if (start) begin
                m_adv = 0;
            end else if (abort || e_done == 1) begin
                m_run = 1'b0;
                m_adv = 0;
            end else if (!pause) begin
                m_adv++;
            end
        end
    end

    task automatic go_to(int c);
        repeat (c - (cyc - t0)) @(posedge clk);
        #1;
    endtask

    task automatic begin_roll();
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b1;
        go_to(1);
        start = 1'b0;
    endtask

    initial begin
        int exp[$];
        int acc;
        acc = 0;
        for (int k = 0; k < TOTAL; k++) begin
            acc += BP << (k / TPP);
            E[k] = acc;
        end

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // 1: full roll
        begin_roll();
        go_to(62);
        exp = {4, 8, 16, 24, 40, 56};
        chk_list("s1_ticks", tick_q, t0, t0 + 62, exp);
        exp = {56};
        chk_list("s1_done", done_q, t0, t0 + 62, exp);
        chk("s1_busy0", busy_log[t0], 0);
        chk("s1_busy1", busy_log[t0 + 1], 1);
        chk("s1_busy56", busy_log[t0 + 56], 1);
        chk("s1_busy57", busy_log[t0 + 57], 0);
        chk("s1_phase8", phase_log[t0 + 8], 0);
        chk("s1_phase9", phase_log[t0 + 9], 1);
        chk("s1_phase24", phase_log[t0 + 24], 1);
        chk("s1_phase25", phase_log[t0 + 25], 2);

        // 2: abort in cycle 10
        begin_roll();
        go_to(10); abort = 1'b1;
        go_to(11); abort = 1'b0;
        go_to(70);
        exp = {4, 8};
        chk_list("s2_ticks", tick_q, t0, t0 + 70, exp);
        exp.delete();
        chk_list("s2_done", done_q, t0, t0 + 70, exp);
        chk("s2_busy10", busy_log[t0 + 10], 1);
        chk("s2_busy11", busy_log[t0 + 11], 0);

        // 3: restart coincident with the third tick
        begin_roll();
        go_to(16); start = 1'b1;
        go_to(17); start = 1'b0;
        go_to(80);
        exp = {4, 8, 16, 20, 24, 32, 40, 56, 72};
        chk_list("s3_ticks", tick_q, t0, t0 + 80, exp);
        exp = {72};
        chk_list("s3_done", done_q, t0, t0 + 80, exp);

        // 4: asynchronous reset mid-roll in cycle 30
        begin_roll();
        go_to(30);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_rst_tick", int'(tick), 0);
        chk("s4_rst_done", int'(done), 0);
        chk("s4_rst_busy", int'(busy), 0);
        chk("s4_rst_phase", int'(phase), 0);
        go_to(31);
        rst_n = 1'b1;
        go_to(70);
        exp = {4, 8, 16, 24};
        chk_list("s4_ticks", tick_q, t0, t0 + 70, exp);
        exp.delete();
        chk_list("s4_done", done_q, t0, t0 + 70, exp);
        begin_roll();
        go_to(10);
        exp = {4, 8};
        chk_list("s4_reroll", tick_q, t0, t0 + 10, exp);
        go_to(62);

        // 5: start and abort together in cycle 6
        begin_roll();
        go_to(6); start = 1'b1; abort = 1'b1;
        go_to(7); start = 1'b0; abort = 1'b0;
        go_to(70);
        exp = {4, 10, 14, 22, 30, 46, 62};
        chk_list("s5_ticks", tick_q, t0, t0 + 70, exp);
        exp = {62};
        chk_list("s5_done", done_q, t0, t0 + 70, exp);

`ifdef ROLL_TICK_PAUSE_EN
        // 6: pause in cycles 5-9
        begin_roll();
        go_to(5); pause = 1'b1;
        go_to(10); pause = 1'b0;
        go_to(68);
        exp = {4, 13, 21, 29, 45, 61};
        chk_list("s6_ticks", tick_q, t0, t0 + 68, exp);
        exp = {61};
        chk_list("s6_done", done_q, t0, t0 + 68, exp);
`endif

        repeat (4) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
